// File: rtl/regfile_scoreboard.sv
// Register-file hazard scoreboard for the decode stage.
// Tracks destination registers issued past decode but not yet written back,
// and holds decode on read-after-write hazards or a full in-flight window.
module regfile_scoreboard #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_write,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] inflight,
  output logic             wb_error,
  output logic [15:0]      stall_cycles
);

  // Per-register pending-write counters; entry 0 is kept at zero.
  logic [31:0][CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]       inflight_q, inflight_d;
  logic                   wb_error_q, wb_error_d;
  logic [15:0]            stall_q, stall_d;

  // One "has pending write" flag per register, used by the hazard lookups.
  logic [31:0] pend_nz;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_nz
      assign pend_nz[gi] = |pend_q[gi];
    end
  endgenerate

  logic hazard_rs1, hazard_rs2, window_full;
  logic track, wb_hit, wb_miss;

  // Hazard/ready decode: purely combinational from current state and issue inputs.
  always_comb begin
    hazard_rs1  = issue_rs1_used && (issue_rs1 != 5'd0) && pend_nz[issue_rs1];
    hazard_rs2  = issue_rs2_used && (issue_rs2 != 5'd0) && pend_nz[issue_rs2];
    window_full = issue_rd_write && (issue_rd != 5'd0) &&
                  (inflight_q == CNT_W'(PIPE_DEPTH));
    issue_ready = !flush && !hazard_rs1 && !hazard_rs2 && !window_full;
    // Only issues that actually write a real register are tracked.
    track       = issue_valid && issue_ready && issue_rd_write && (issue_rd != 5'd0);
    // A flush discards any same-cycle writeback, including error detection.
    wb_hit      = wb_valid && !flush && (wb_addr != 5'd0) && pend_nz[wb_addr];
    wb_miss     = wb_valid && !flush && (wb_addr != 5'd0) && !pend_nz[wb_addr];
  end

  // Next-state for counters, error flag and stall counter.
  always_comb begin
    pend_d     = pend_q;
    inflight_d = inflight_q;
    wb_error_d = wb_error_q | wb_miss;
    stall_d    = stall_q;
    if (flush) begin
      pend_d     = '0;
      inflight_d = '0;
    end else begin
      // Same-register issue and writeback cancel out: net pend change is zero.
      if (track) begin
        pend_d[issue_rd] = pend_d[issue_rd] + CNT_W'(1);
        inflight_d       = inflight_d + CNT_W'(1);
      end
      if (wb_hit) begin
        pend_d[wb_addr] = pend_d[wb_addr] - CNT_W'(1);
        inflight_d      = inflight_d - CNT_W'(1);
      end
    end
    pend_d[0] = '0;
    if (issue_valid && !issue_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      inflight_q <= '0;
      wb_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      wb_error_q <= wb_error_d;
      stall_q    <= stall_d;
    end
  end

  assign inflight     = inflight_q;
  assign busy         = (inflight_q != '0);
  assign wb_error     = wb_error_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes expected per-cycle
// outputs from a reference model; a monitor pops and compares on the falling edge.
module tb_regfile_scoreboard;

  localparam int DEPTH = 3;
  localparam int CW    = 3;

  logic          clock, reset_n;
  logic          issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_write;
  logic [4:0]    issue_rs1, issue_rs2, issue_rd, wb_addr;
  logic          issue_ready, wb_valid, flush, busy, wb_error;
  logic [CW-1:0] inflight;
  logic [15:0]   stall_cycles;

  regfile_scoreboard #(.PIPE_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_write(issue_rd_write), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .busy(busy), .inflight(inflight), .wb_error(wb_error), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int ready; int infl; int busy; int err; int stall; int req;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding writes per register, error flag, stall count.
  int m_pend[32];
  bit m_err;
  int m_stall;

  function automatic int m_inflight();
    int s = 0;
    for (int r = 0; r < 32; r++) s += m_pend[r];
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_err = 0;
    m_stall = 0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs with the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_ready", int'(issue_ready), e.ready);
        if (e.req >= 0) chk("directed_ready", int'(issue_ready), e.req);
        chk("inflight", int'(inflight), e.infl);
        chk("busy", int'(busy), e.busy);
        chk("wb_error", int'(wb_error), e.err);
        chk("stall_cycles", int'(stall_cycles), e.stall);
        $display("cycle t=%0t ready=%0b inflight=%0d busy=%0b err=%0b stall=%0d",
                 $time, issue_ready, inflight, busy, wb_error, stall_cycles);
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge.
  task automatic step(input bit iv, input logic [4:0] rs1, input bit rs1u,
                      input logic [4:0] rs2, input bit rs2u,
                      input logic [4:0] rd, input bit rdw,
                      input bit wbv, input logic [4:0] wba, input bit fl, input int req);
    exp_t e;
    bit rdy;
    int inf;
    issue_valid = iv; issue_rs1 = rs1; issue_rs1_used = rs1u;
    issue_rs2 = rs2; issue_rs2_used = rs2u; issue_rd = rd; issue_rd_write = rdw;
    wb_valid = wbv; wb_addr = wba; flush = fl;
    inf = m_inflight();
    rdy = !fl && !(rs1u && rs1 != 0 && m_pend[rs1] > 0)
               && !(rs2u && rs2 != 0 && m_pend[rs2] > 0)
               && !(rdw && rd != 0 && inf == DEPTH);
    e.ready = int'(rdy); e.infl = inf; e.busy = (inf != 0) ? 1 : 0;
    e.err = int'(m_err); e.stall = m_stall; e.req = req;
    exp_q.push_back(e);
    @(posedge clock);
    // Apply the cycle's effect to the model using pre-edge state.
    if (iv && !rdy && m_stall < 65535) m_stall++;
    if (fl) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      bit wb_good;
      wb_good = 0;
      if (wbv && wba != 0) begin
        if (m_pend[wba] > 0) wb_good = 1;
        else m_err = 1;
      end
      if (iv && rdy && rdw && rd != 0) m_pend[rd]++;
      if (wb_good) m_pend[wba]--;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
    issue_rd = 0; issue_rd_write = 0; wb_valid = 0; wb_addr = 0; flush = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", int'(issue_ready), 1);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wb_error", int'(wb_error), 0);
    chk("rst_stall", int'(stall_cycles), 0);
    reset_n = 1'b1;

    // RAW on x5: stall, writeback, ready the cycle after.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    // Untracked issues and x0 reads.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);

    // WAW on x7.
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
    step(1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 0);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 0);
    step(1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 1);

    // Full window.
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, -1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, -1);

    // Same-cycle issue and writeback on x9, then flush.
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 1);
    step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 10, 1, 1, 12, 1, 0);
    step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    // Writeback with nothing pending: sticky error.
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, -1);
    idle();
    step(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 1);
    step(1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges with x15 pending and a dependent read.
    issue_valid = 1; issue_rs1 = 15; issue_rs1_used = 1; issue_rd_write = 0;
    wb_valid = 0; flush = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_ready", int'(issue_ready), 1);
    chk("async_inflight", int'(inflight), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_wb_error", int'(wb_error), 0);
    chk("async_stall", int'(stall_cycles), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      bit wbv;
      logic [4:0] wba;
      wbv = ($urandom_range(0, 9) < 4);
      wba = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
           wbv, wba, ($urandom_range(0, 29) == 0), -1);
    end
    idle();

    @(negedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
